// File: rtl/round_key_add.sv
// AES-128 AddRoundKey stage with an on-the-fly key schedule.
// Walks the round keys forward (EN=1) or backward from round 10 (EN=0), one key per accepted block.
module round_key_add #(
   parameter bit EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   input  logic [127:0] key_in,
   output logic         key_ready,
   input  logic         in_valid,
   input  logic [127:0] data_in,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic [3:0]   round_out,
   output logic         last
);

   typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   state_t       state_q, state_d;
   logic [127:0] cur_key_q, cur_key_d;
   logic [127:0] base_key_q, base_key_d;
   logic [127:0] data_q, data_d;
   logic [3:0]   step_q, step_d;
   logic [3:0]   round_q, round_d;
   logic         out_valid_q, out_valid_d;
   logic         last_q, last_d;

   logic         key_acc, in_acc, inverse;
   logic [31:0]  w0, w1, w2, w3, inv_w3, sub_in, sub_out, rcon_w;
   logic [31:0]  f0, f1, f2, f3, i0, i1, i2;
   logic [3:0]   cur_round, rcon_idx;
   logic [127:0] next_key;

   assign key_ready = (state_q != PREP) && !out_valid_q;
   assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready) && !key_valid;
   assign key_acc   = key_valid && key_ready;
   assign in_acc    = in_valid && in_ready;

   assign out_valid = out_valid_q;
   assign data_out  = data_q;
   assign round_out = round_q;
   assign last      = last_q;

   // One S-box path: the inverse step needs SubWord of the already-recovered w3.
   assign {w0, w1, w2, w3} = cur_key_q;
   assign inverse   = !EN && (state_q == RUN);
   assign inv_w3    = w3 ^ w2;
   assign sub_in    = inverse ? inv_w3 : w3;
   assign sub_out   = {SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]], SBOX[sub_in[31:24]]};
   assign cur_round = EN ? step_q : (4'd10 - step_q);
   assign rcon_idx  = inverse ? cur_round : (step_q + 4'd1);
   assign rcon_w    = {rcon(rcon_idx), 24'h000000};

   assign f0 = w0 ^ sub_out ^ rcon_w;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
   assign i2 = w2 ^ w1;
   assign i1 = w1 ^ w0;
   assign i0 = w0 ^ sub_out ^ rcon_w;
   assign next_key = inverse ? {i0, i1, i2, inv_w3} : {f0, f1, f2, f3};

   always_comb begin
      state_d     = state_q;
      cur_key_d   = cur_key_q;
      base_key_d  = base_key_q;
      step_d      = step_q;
      data_d      = data_q;
      round_d     = round_q;
      last_d      = last_q;
      out_valid_d = out_valid_q && !out_ready;
      if (key_acc) begin
         base_key_d = key_in;
         cur_key_d  = key_in;
         step_d     = 4'd0;
         state_d    = EN ? RUN : PREP;
      end else begin
         case (state_q)
            IDLE: ;
            PREP: begin
               cur_key_d = next_key;
               step_d    = step_q + 4'd1;
               if (step_q == 4'd9) begin
                  base_key_d = next_key;
                  step_d     = 4'd0;
                  state_d    = RUN;
               end
            end
            RUN: begin
               if (in_acc) begin
                  data_d      = data_in ^ cur_key_q;
                  out_valid_d = 1'b1;
                  round_d     = cur_round;
                  last_d      = (step_q == 4'd10);
                  // After the final key, rewind to the sequence start for the next block run.
                  if (step_q == 4'd10) begin
                     cur_key_d = base_key_q;
                     step_d    = 4'd0;
                  end else begin
                     cur_key_d = next_key;
                     step_d    = step_q + 4'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_key_q   <= '0;
         base_key_q  <= '0;
         data_q      <= '0;
         step_q      <= '0;
         round_q     <= '0;
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_key_q   <= cur_key_d;
         base_key_q  <= base_key_d;
         data_q      <= data_d;
         step_q      <= step_d;
         round_q     <= round_d;
         out_valid_q <= out_valid_d;
         last_q      <= last_d;
      end
   end

endmodule

// File: tb/tb_round_key_add.sv
// Bench for round_key_add: one encrypt-order and one decrypt-order instance,
// checked against a FIPS-197 key schedule built from first principles.
module tb_round_key_add;

   localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PAT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PAT2 = 128'hfedcba98765432100123456789abcdef;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         kv [2];
   logic         kr [2];
   logic         iv [2];
   logic         ir [2];
   logic         ov [2];
   logic         ordy [2];
   logic         lst [2];
   logic [127:0] kin [2];
   logic [127:0] din [2];
   logic [127:0] dout [2];
   logic [3:0]   rnd [2];

   always #5 clk = ~clk;

   round_key_add #(.EN(1'b1)) u_enc (
      .clk(clk), .rst_n(rst_n),
      .key_valid(kv[0]), .key_in(kin[0]), .key_ready(kr[0]),
      .in_valid(iv[0]), .data_in(din[0]), .in_ready(ir[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout[0]),
      .round_out(rnd[0]), .last(lst[0])
   );

   round_key_add #(.EN(1'b0)) u_dec (
      .clk(clk), .rst_n(rst_n),
      .key_valid(kv[1]), .key_in(kin[1]), .key_ready(kr[1]),
      .in_valid(iv[1]), .data_in(din[1]), .in_ready(ir[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout[1]),
      .round_out(rnd[1]), .last(lst[1])
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]   sb [256];
   logic [127:0] rk [2][11];
   bit           have_key [2];
   bit           key_seen [2];
   int           pos [2];
   logic [127:0] fifo [2][16];
   int           wr [2];
   int           rd [2];
   int           acc_cnt [2];
   int           out_cnt [2];
   logic [127:0] cap_d [2][16];
   logic [3:0]   cap_r [2][16];
   logic         cap_l [2][16];
   bit           hold_p [2];
   logic [127:0] hold_d [2];
   logic [3:0]   hold_r [2];
   logic         hold_l [2];
   logic [127:0] blk [16];

   typedef struct {
      int           s;
      int           n;
      logic [127:0] d;
      logic [127:0] e;
      logic [3:0]   r;
      logic         l;
   } vec_t;
   vec_t vt [7];

   task automatic check(input string name, input int s, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d: got %h expected %h", name, s, act, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic expand(input logic [127:0] k, input int s);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[s][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         have_key[s] = 1'b0; pos[s] = 0; wr[s] = 0; rd[s] = 0;
         acc_cnt[s] = 0; out_cnt[s] = 0; hold_p[s] = 1'b0;
      end
   endtask

   // Sampled at the falling edge: handshake values here are those seen by the next rising edge.
   task automatic monitor();
      for (int s = 0; s < 2; s++) begin
         if (hold_p[s]) begin
            check("stall_valid", s, 128'(ov[s]), 128'd1);
            check("stall_data", s, dout[s], hold_d[s]);
            check("stall_round", s, 128'(rnd[s]), 128'(hold_r[s]));
            check("stall_last", s, 128'(lst[s]), 128'(hold_l[s]));
         end
         hold_p[s] = ov[s] && !ordy[s];
         hold_d[s] = dout[s]; hold_r[s] = rnd[s]; hold_l[s] = lst[s];
         if (ov[s] && ordy[s]) begin
            if (wr[s] == rd[s]) begin
               check("out_without_accept", s, 128'(wr[s] - rd[s]), 128'd1);
            end else begin
               int r;
               logic [127:0] d;
               d = fifo[s][rd[s] % 16];
               rd[s]++;
               r = (s == 0) ? pos[s] : 10 - pos[s];
               check("data", s, dout[s], d ^ rk[s][r]);
               check("round", s, 128'(rnd[s]), 128'(r));
               check("last", s, 128'(lst[s]), 128'(pos[s] == 10));
               pos[s] = (pos[s] + 1) % 11;
            end
            if (out_cnt[s] < 16) begin
               cap_d[s][out_cnt[s]] = dout[s];
               cap_r[s][out_cnt[s]] = rnd[s];
               cap_l[s][out_cnt[s]] = lst[s];
            end
            out_cnt[s]++;
            $display("inst%0d out round=%0d last=%0b data=%h", s, rnd[s], lst[s], dout[s]);
         end
         if (iv[s] && ir[s]) begin
            check("accept_has_key", s, 128'(have_key[s]), 128'd1);
            fifo[s][wr[s] % 16] = din[s];
            wr[s]++;
            acc_cnt[s]++;
         end
         if (kv[s] && kr[s]) begin
            expand(kin[s], s);
            have_key[s] = 1'b1; key_seen[s] = 1'b1;
            pos[s] = 0; out_cnt[s] = 0; acc_cnt[s] = 0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input int s, input logic [127:0] k);
      int g;
      g = 0;
      kin[s] = k; kv[s] = 1'b1; key_seen[s] = 1'b0;
      while (!key_seen[s] && g < 40) begin tick(); g++; end
      kv[s] = 1'b0;
      check("key_load", s, 128'(key_seen[s]), 128'd1);
   endtask

   task automatic settle(input int s, output int low);
      int g;
      g = 0;
      while (!kr[s] && g < 30) begin
         check("in_ready_prep", s, 128'(ir[s]), 128'd0);
         tick(); g++;
      end
      low = g;
   endtask

   task automatic drain(input int s);
      int g;
      g = 0;
      iv[s] = 1'b0; ordy[s] = 1'b1;
      while (ov[s] && g < 20) begin tick(); g++; end
      check("drain", s, 128'(ov[s]), 128'd0);
   endtask

   task automatic stream(input int s, input int n);
      int start, g;
      start = acc_cnt[s]; g = 0;
      ordy[s] = 1'b1;
      while (acc_cnt[s] - start < n && g < 100) begin
         din[s] = blk[acc_cnt[s] - start];
         iv[s] = 1'b1;
         tick(); g++;
      end
      iv[s] = 1'b0;
      check("stream_accepts", s, 128'(acc_cnt[s] - start), 128'(n));
      drain(s);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int low;
      logic [127:0] k2;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      for (int s = 0; s < 2; s++) begin
         kv[s] = 1'b0; iv[s] = 1'b0; ordy[s] = 1'b1; kin[s] = '0; din[s] = '0;
      end
      model_reset();

      vt[0] = '{0, 0,  128'h0, KEY, 4'd0, 1'b0};
      vt[1] = '{0, 1,  128'h0, 128'ha0fafe1788542cb123a339392a6c7605, 4'd1, 1'b0};
      vt[2] = '{0, 10, 128'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 1'b1};
      vt[3] = '{0, 11, PAT, PAT ^ KEY, 4'd0, 1'b0};
      vt[4] = '{1, 0,  128'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 1'b0};
      vt[5] = '{1, 10, 128'h0, KEY, 4'd0, 1'b1};
      vt[6] = '{1, 11, PAT, PAT ^ 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 1'b0};

      // Reset values while rst_n is held low.
      #12;
      for (int s = 0; s < 2; s++) begin
         check("rst_out_valid", s, 128'(ov[s]), 128'd0);
         check("rst_data", s, dout[s], 128'd0);
         check("rst_round", s, 128'(rnd[s]), 128'd0);
         check("rst_last", s, 128'(lst[s]), 128'd0);
         check("rst_key_ready", s, 128'(kr[s]), 128'd1);
         check("rst_in_ready", s, 128'(ir[s]), 128'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Known-answer sequences, including the wrap to a 12th block.
      for (int s = 0; s < 2; s++) begin
         load_key(s, KEY);
         settle(s, low);
         check("key_ready_low_cycles", s, 128'(low), (s == 0) ? 128'd0 : 128'd10);
         for (int n = 0; n < 16; n++) blk[n] = '0;
         for (int v = 0; v < 7; v++) if (vt[v].s == s) blk[vt[v].n] = vt[v].d;
         stream(s, 12);
         for (int v = 0; v < 7; v++) begin
            if (vt[v].s == s) begin
               check("kat_data", s, cap_d[s][vt[v].n], vt[v].e);
               check("kat_round", s, 128'(cap_r[s][vt[v].n]), 128'(vt[v].r));
               check("kat_last", s, 128'(cap_l[s][vt[v].n]), 128'(vt[v].l));
            end
         end
      end

      // Random traffic with stalls and occasional key reloads.
      for (int s = 0; s < 2; s++) begin
         load_key(s, {$urandom, $urandom, $urandom, $urandom});
         for (int c = 0; c < 300; c++) begin
            iv[s]   = ($urandom % 4) != 0;
            din[s]  = {$urandom, $urandom, $urandom, $urandom};
            ordy[s] = ($urandom % 4) != 0;
            kv[s]   = ($urandom % 40) == 0;
            kin[s]  = {$urandom, $urandom, $urandom, $urandom};
            tick();
         end
         kv[s] = 1'b0;
         drain(s);
         check("drain_empty", s, 128'(wr[s] - rd[s]), 128'd0);
      end

      // Five-cycle output stall, then release with a same-cycle accept.
      load_key(0, KEY);
      settle(0, low);
      din[0] = PAT; iv[0] = 1'b1; ordy[0] = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", 0, 128'(ir[0]), 128'd0);
         check("stall_key_ready", 0, 128'(kr[0]), 128'd0);
         check("stall_out_valid", 0, 128'(ov[0]), 128'd1);
         tick();
      end
      din[0] = PAT2; ordy[0] = 1'b1;
      #1;
      check("release_in_ready", 0, 128'(ir[0]), 128'd1);
      tick();
      drain(0);
      check("stall_outputs", 0, 128'(out_cnt[0]), 128'd2);
      check("stall_second", 0, cap_d[0][1], PAT2 ^ 128'ha0fafe1788542cb123a339392a6c7605);

      // Key load wins over a same-cycle block.
      k2 = {$urandom, $urandom, $urandom, $urandom};
      kin[0] = k2; kv[0] = 1'b1; din[0] = PAT; iv[0] = 1'b1;
      #1;
      check("prio_in_ready", 0, 128'(ir[0]), 128'd0);
      tick();
      kv[0] = 1'b0;
      tick();
      drain(0);
      check("prio_accepts", 0, 128'(acc_cnt[0]), 128'd1);
      check("prio_data", 0, cap_d[0][0], PAT ^ k2);
      check("prio_round", 0, 128'(cap_r[0][0]), 128'd0);

      // Asynchronous reset in the middle of key preparation.
      load_key(1, KEY);
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #1;
      check("midprep_out_valid", 1, 128'(ov[1]), 128'd0);
      check("midprep_data", 1, dout[1], 128'd0);
      check("midprep_round", 1, 128'(rnd[1]), 128'd0);
      check("midprep_last", 1, 128'(lst[1]), 128'd0);
      check("midprep_key_ready", 1, 128'(kr[1]), 128'd1);
      check("midprep_in_ready", 1, 128'(ir[1]), 128'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      din[1] = PAT; iv[1] = 1'b1; ordy[1] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         check("nokey_in_ready", 1, 128'(ir[1]), 128'd0);
         tick();
      end
      load_key(1, KEY);
      settle(1, low);
      check("reload_low_cycles", 1, 128'(low), 128'd10);
      for (int n = 0; n < 16; n++) blk[n] = '0;
      stream(1, 11);
      check("reload_first", 1, cap_d[1][0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("reload_final", 1, cap_d[1][10], KEY);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
